// File: rtl/spec_free_list_pkg.sv
// Shared constants and types for the speculative physical-register free list.
// Latency: n/a (package only).
// Backpressure: n/a.
package spec_free_list_pkg;

   localparam int PHYS_REGS    = 96;
   localparam int ARCH_REGS    = 32;
   localparam int PHYS_LOG     = 7;
   localparam int DEPTH        = PHYS_REGS - ARCH_REGS;
   localparam int DEPTH_LOG    = 6;
   localparam int COMMIT_WIDTH = 4;
   localparam int RENAME_WIDTH = 4;

   typedef logic [PHYS_LOG-1:0]  phys_tag_t;
   // DEPTH is exactly 2**DEPTH_LOG, so mod-DEPTH pointer math is plain wrap.
   typedef logic [DEPTH_LOG-1:0] fl_ptr_t;
   typedef logic [DEPTH_LOG:0]   fl_cnt_t;

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

endpackage

// File: rtl/spec_free_list_compact.sv
// Packs a sparse 4-slot valid vector into consecutive write offsets.
// Latency: purely combinational. Backpressure: none.
// Ports: valid_i (slot valids) -> offset_o[k] (write offset of slot k), n_push_o (popcount).
module free_list_compact
   import spec_free_list_pkg::*;
(
   input  logic [COMMIT_WIDTH-1:0]      valid_i,
   output logic [COMMIT_WIDTH-1:0][1:0] offset_o,
   output logic [2:0]                   n_push_o
);

   // Offset of slot k is the number of valid slots below it; only meaningful
   // when valid_i[k] is set.
   always_comb begin
      offset_o[0] = 2'd0;
      offset_o[1] = {1'b0, valid_i[0]};
      offset_o[2] = {1'b0, valid_i[0]} + {1'b0, valid_i[1]};
      offset_o[3] = {1'b0, valid_i[0]} + {1'b0, valid_i[1]} + {1'b0, valid_i[2]};
      n_push_o    = popcnt4(valid_i);
   end

endmodule

// File: rtl/spec_free_list.sv
// Speculative free list: circular buffer of free physical tags feeding rename, refilled by commit.
// Latency: tags are combinational from registered state; pops/pushes take effect at the clock edge.
// Backpressure: stall_o when requested slots exceed the registered occupancy (no partial allocation).
// Ports: reqValidK_i / freeTagK_o / stall_o (rename side), releasedValidK_i / releasedTagK_i
//        (commit side), recoverFlag_i (flush), freeCnt_o (registered occupancy).
module spec_free_list
   import spec_free_list_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            reqValid0_i,
   input  logic            reqValid1_i,
   input  logic            reqValid2_i,
   input  logic            reqValid3_i,
   output phys_tag_t       freeTag0_o,
   output phys_tag_t       freeTag1_o,
   output phys_tag_t       freeTag2_o,
   output phys_tag_t       freeTag3_o,
   output logic            stall_o,
   input  logic            releasedValid0_i,
   input  logic            releasedValid1_i,
   input  logic            releasedValid2_i,
   input  logic            releasedValid3_i,
   input  phys_tag_t       releasedTag0_i,
   input  phys_tag_t       releasedTag1_i,
   input  phys_tag_t       releasedTag2_i,
   input  phys_tag_t       releasedTag3_i,
   input  logic            recoverFlag_i,
   output fl_cnt_t         freeCnt_o
);

   phys_tag_t entry_q [DEPTH];
   phys_tag_t entry_d [DEPTH];
   fl_ptr_t   head_q, head_d;
   fl_ptr_t   tail_q, tail_d;
   fl_cnt_t   count_q, count_d;

   logic [RENAME_WIDTH-1:0]      req_vec;
   logic [COMMIT_WIDTH-1:0]      rel_vld;
   phys_tag_t                    rel_tag [COMMIT_WIDTH];
   logic [COMMIT_WIDTH-1:0][1:0] rel_off;
   logic [2:0]                   n_req, n_pop, n_push;
   fl_ptr_t                      tail_next;
   fl_ptr_t                      rd_ptr [RENAME_WIDTH];
   fl_ptr_t                      wr_ptr [COMMIT_WIDTH];
   logic [DEPTH_LOG+1:0]         count_sum;

   assign req_vec = {reqValid3_i, reqValid2_i, reqValid1_i, reqValid0_i};
   assign rel_vld = {releasedValid3_i, releasedValid2_i, releasedValid1_i, releasedValid0_i};
   assign rel_tag[0] = releasedTag0_i;
   assign rel_tag[1] = releasedTag1_i;
   assign rel_tag[2] = releasedTag2_i;
   assign rel_tag[3] = releasedTag3_i;

   free_list_compact u_compact (
      .valid_i  (rel_vld),
      .offset_o (rel_off),
      .n_push_o (n_push)
   );

   assign n_req = popcnt4(req_vec);

   // Stall compares against the registered count only; same-cycle releases
   // are deliberately not bypassed. Recovery suppresses allocation entirely.
   assign stall_o = !recoverFlag_i && (fl_cnt_t'(n_req) > count_q);
   assign n_pop   = (stall_o || recoverFlag_i) ? 3'd0 : n_req;

   assign tail_next = tail_q + fl_ptr_t'(n_push);
   assign count_sum = {1'b0, count_q} + {5'b0, n_push} - {5'b0, n_pop};

   always_comb begin
      for (int k = 0; k < RENAME_WIDTH; k++) begin
         rd_ptr[k] = head_q + fl_ptr_t'(k);
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         wr_ptr[k] = tail_q + fl_ptr_t'(rel_off[k]);
      end
   end

   assign freeTag0_o = entry_q[rd_ptr[0]];
   assign freeTag1_o = entry_q[rd_ptr[1]];
   assign freeTag2_o = entry_q[rd_ptr[2]];
   assign freeTag3_o = entry_q[rd_ptr[3]];
   assign freeCnt_o  = count_q;

   always_comb begin
      entry_d = entry_q;
      head_d  = head_q + fl_ptr_t'(n_pop);
      tail_d  = tail_next;
      count_d = count_sum[DEPTH_LOG:0];

      // Releases are written even during recovery.
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
         if (rel_vld[k]) begin
            entry_d[wr_ptr[k]] = rel_tag[k];
         end
      end

      // Everything between head and tail is speculatively allocated;
      // snapping head to the new tail returns all of it at once.
      if (recoverFlag_i) begin
         head_d  = tail_next;
         count_d = fl_cnt_t'(DEPTH);
      end

      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = phys_tag_t'(ARCH_REGS + i);
         end
         head_d  = '0;
         tail_d  = '0;
         count_d = fl_cnt_t'(DEPTH);
      end
   end

   always_ff @(posedge clk) begin
      entry_q <= entry_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && !recoverFlag_i) begin
         assert ((req_vec & (req_vec + 4'd1)) == 4'd0)
            else $error("spec_free_list: non-prefix rename request %b", req_vec);
         assert (count_sum <= (DEPTH_LOG+2)'(DEPTH))
            else $error("spec_free_list: occupancy overflow %0d", count_sum);
      end
   end
`endif

endmodule

// File: tb/tb_spec_free_list.sv
module tb_spec_free_list;
   import spec_free_list_pkg::*;

   typedef struct packed {
      logic            rst;
      logic [3:0]      req;
      logic [3:0]      rvld;
      logic [3:0][6:0] rtag;
      logic            rec;
      logic            chk_pre;
      logic            exp_stall;
      logic            chk_tags;
      logic [3:0][6:0] exp_tag;
      logic [6:0]      exp_cnt;
   } vec_t;

   logic      clk;
   logic      reset;
   logic      reqValid0_i, reqValid1_i, reqValid2_i, reqValid3_i;
   phys_tag_t freeTag0_o, freeTag1_o, freeTag2_o, freeTag3_o;
   logic      stall_o;
   logic      releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i;
   phys_tag_t releasedTag0_i, releasedTag1_i, releasedTag2_i, releasedTag3_i;
   logic      recoverFlag_i;
   fl_cnt_t   freeCnt_o;

   int checks = 0;
   int errors = 0;
   vec_t tbl [26];

   spec_free_list dut (
      .clk              (clk),
      .reset            (reset),
      .reqValid0_i      (reqValid0_i),
      .reqValid1_i      (reqValid1_i),
      .reqValid2_i      (reqValid2_i),
      .reqValid3_i      (reqValid3_i),
      .freeTag0_o       (freeTag0_o),
      .freeTag1_o       (freeTag1_o),
      .freeTag2_o       (freeTag2_o),
      .freeTag3_o       (freeTag3_o),
      .stall_o          (stall_o),
      .releasedValid0_i (releasedValid0_i),
      .releasedValid1_i (releasedValid1_i),
      .releasedValid2_i (releasedValid2_i),
      .releasedValid3_i (releasedValid3_i),
      .releasedTag0_i   (releasedTag0_i),
      .releasedTag1_i   (releasedTag1_i),
      .releasedTag2_i   (releasedTag2_i),
      .releasedTag3_i   (releasedTag3_i),
      .recoverFlag_i    (recoverFlag_i),
      .freeCnt_o        (freeCnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0][6:0] tg(input int a, input int b, input int c, input int d);
      logic [3:0][6:0] r;
      r[0] = 7'(a); r[1] = 7'(b); r[2] = 7'(c); r[3] = 7'(d);
      return r;
   endfunction

   function automatic vec_t mk(input logic rst, input logic [3:0] req, input logic [3:0] rvld,
                               input logic [3:0][6:0] rtag, input logic rec, input logic chk_pre,
                               input logic exp_stall, input logic chk_tags,
                               input logic [3:0][6:0] exp_tag, input int exp_cnt);
      vec_t v;
      v.rst = rst; v.req = req; v.rvld = rvld; v.rtag = rtag; v.rec = rec;
      v.chk_pre = chk_pre; v.exp_stall = exp_stall; v.chk_tags = chk_tags;
      v.exp_tag = exp_tag; v.exp_cnt = 7'(exp_cnt);
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic apply(input vec_t v, input string nm);
      logic [3:0][6:0] ft;
      @(negedge clk);
      reset            = v.rst;
      reqValid0_i      = v.req[0];
      reqValid1_i      = v.req[1];
      reqValid2_i      = v.req[2];
      reqValid3_i      = v.req[3];
      releasedValid0_i = v.rvld[0];
      releasedValid1_i = v.rvld[1];
      releasedValid2_i = v.rvld[2];
      releasedValid3_i = v.rvld[3];
      releasedTag0_i   = v.rtag[0];
      releasedTag1_i   = v.rtag[1];
      releasedTag2_i   = v.rtag[2];
      releasedTag3_i   = v.rtag[3];
      recoverFlag_i    = v.rec;
      #1;
      ft = {freeTag3_o, freeTag2_o, freeTag1_o, freeTag0_o};
      if (v.chk_pre) begin
         chk({nm, " stall"}, int'(stall_o), int'(v.exp_stall));
         if (v.chk_tags) begin
            for (int k = 0; k < 4; k++) begin
               chk($sformatf("%s tag%0d", nm, k), int'(ft[k]), int'(v.exp_tag[k]));
            end
         end
      end
      @(posedge clk);
      #1;
      chk({nm, " cnt"}, int'(freeCnt_o), int'(v.exp_cnt));
   endtask

   initial begin
      vec_t v;
      reset = 1'b1;
      {reqValid0_i, reqValid1_i, reqValid2_i, reqValid3_i} = '0;
      {releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i} = '0;
      {releasedTag0_i, releasedTag1_i, releasedTag2_i, releasedTag3_i} = '0;
      recoverFlag_i = 1'b0;

      // reset / idle
      tbl[0]  = mk(1, 4'h0, 4'h0, tg(0,0,0,0), 0, 0, 0, 0, tg(0,0,0,0), 64);
      tbl[1]  = mk(0, 4'h0, 4'h0, tg(0,0,0,0), 0, 1, 0, 1, tg(32,33,34,35), 64);
      // count=2: refill two, over-request stalls, then exact request drains
      tbl[2]  = mk(0, 4'h0, 4'b0011, tg(10,11,0,0), 0, 1, 0, 0, tg(0,0,0,0), 2);
      tbl[3]  = mk(0, 4'b0111, 4'h0, tg(0,0,0,0), 0, 1, 1, 1, tg(10,11,34,35), 2);
      tbl[4]  = mk(0, 4'b0011, 4'h0, tg(0,0,0,0), 0, 1, 0, 1, tg(10,11,34,35), 0);
      // sparse release at tail=62 (slots 0 and 2), then refill entries 0,1
      tbl[5]  = mk(0, 4'h0, 4'b0101, tg(5,127,9,127), 0, 1, 0, 0, tg(0,0,0,0), 62);
      tbl[6]  = mk(0, 4'h0, 4'b0011, tg(20,21,0,0), 0, 1, 0, 0, tg(0,0,0,0), 64);
      // pop group straddling entry 63 -> 0
      tbl[7]  = mk(0, 4'hF, 4'h0, tg(0,0,0,0), 0, 1, 0, 1, tg(5,9,20,21), 0);
      // build count=10 then simultaneous push/pop
      tbl[8]  = mk(0, 4'h0, 4'hF, tg(50,51,52,53), 0, 1, 0, 0, tg(0,0,0,0), 4);
      tbl[9]  = mk(0, 4'h0, 4'hF, tg(54,55,56,57), 0, 1, 0, 0, tg(0,0,0,0), 8);
      tbl[10] = mk(0, 4'h0, 4'b0011, tg(58,59,0,0), 0, 1, 0, 0, tg(0,0,0,0), 10);
      tbl[11] = mk(0, 4'hF, 4'hF, tg(60,61,62,63), 0, 1, 0, 1, tg(50,51,52,53), 10);
      tbl[12] = mk(0, 4'hF, 4'h0, tg(0,0,0,0), 0, 1, 0, 1, tg(54,55,56,57), 6);
      tbl[13] = mk(0, 4'hF, 4'h0, tg(0,0,0,0), 0, 1, 0, 1, tg(58,59,60,61), 2);
      // recovery with count<nReq: stall forced low, ring refilled
      tbl[14] = mk(0, 4'hF, 4'h0, tg(0,0,0,0), 1, 1, 0, 1, tg(62,63,14,15), 64);
      // reset mid-operation with every other input active
      tbl[15] = mk(1, 4'hF, 4'hF, tg(1,2,3,4), 1, 1, 0, 1, tg(14,15,16,17), 64);
      tbl[16] = mk(0, 4'h0, 4'h0, tg(0,0,0,0), 0, 1, 0, 1, tg(32,33,34,35), 64);
      // 20 allocations, 6 releases, then recovery releasing tag 40
      for (int c = 0; c < 5; c++) begin
         tbl[17+c] = mk(0, 4'hF, 4'h0, tg(0,0,0,0), 0, 1, 0, 1,
                        tg(32+4*c, 33+4*c, 34+4*c, 35+4*c), 60-4*c);
      end
      tbl[22] = mk(0, 4'h0, 4'hF, tg(70,71,72,73), 0, 1, 0, 0, tg(0,0,0,0), 48);
      tbl[23] = mk(0, 4'h0, 4'b0011, tg(74,75,0,0), 0, 1, 0, 0, tg(0,0,0,0), 50);
      tbl[24] = mk(0, 4'hF, 4'b0001, tg(40,0,0,0), 1, 1, 0, 1, tg(52,53,54,55), 64);
      tbl[25] = mk(0, 4'hF, 4'h0, tg(0,0,0,0), 0, 1, 0, 1, tg(39,40,41,42), 60);

      for (int i = 0; i <= 1; i++) apply(tbl[i], $sformatf("v%0d", i));

      // drain all 64 tags in order, then a 17th request must stall with head unmoved
      for (int c = 0; c <= 16; c++) begin
         if (c < 16)
            v = mk(0, 4'hF, 4'h0, tg(0,0,0,0), 0, 1, 0, 1,
                   tg(32+4*c, 33+4*c, 34+4*c, 35+4*c), 60-4*c);
         else
            v = mk(0, 4'hF, 4'h0, tg(0,0,0,0), 0, 1, 1, 1, tg(32,33,34,35), 0);
         apply(v, $sformatf("drain%0d", c));
      end

      for (int i = 2; i <= 4; i++) apply(tbl[i], $sformatf("v%0d", i));

      // push 60 tags (values 0..59) into entries 2..61, bringing tail to 62
      for (int c = 0; c < 15; c++) begin
         v = mk(0, 4'h0, 4'hF, tg(4*c, 4*c+1, 4*c+2, 4*c+3), 0, 1, 0, 0, tg(0,0,0,0), 4*(c+1));
         apply(v, $sformatf("fill%0d", c));
      end

      for (int i = 5; i <= 6; i++) apply(tbl[i], $sformatf("v%0d", i));

      // pop those 60 back in order
      for (int c = 0; c < 15; c++) begin
         v = mk(0, 4'hF, 4'h0, tg(0,0,0,0), 0, 1, 0, 1,
                tg(4*c, 4*c+1, 4*c+2, 4*c+3), 60-4*c);
         apply(v, $sformatf("pop%0d", c));
      end

      for (int i = 7; i <= 25; i++) apply(tbl[i], $sformatf("v%0d", i));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
